// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment character display scheduler.
package seg_pkg;

   localparam logic [7:0] EMPTY     = 8'h00;
   localparam logic [7:0] CHAR_DASH = 8'h40;
   localparam logic [7:0] CHAR_ZERO = 8'h3f;

   localparam int unsigned MSG_CHARS = 8;

   localparam int unsigned SRC_FREE   = 0;
   localparam int unsigned SRC_LEARN  = 1;
   localparam int unsigned SRC_RESULT = 2;

   typedef enum logic {IDLE, SHOW} state_e;

   // Window k shows P[k..k+3] where P = four blanks followed by the message.
   function automatic logic [31:0] window(input logic [63:0] msg, input logic [3:0] k);
      logic [95:0] padded;
      logic [95:0] shifted;
      padded  = {msg, {4{EMPTY}}};
      shifted = padded >> {k, 3'b000};
      return shifted[31:0];
   endfunction

endpackage

// File: rtl/step_timer.sv
// Free-running step counter; tick marks the last cycle of each STEP_CYCLES interval.
module step_timer #(
   parameter int unsigned STEP_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

   logic [CW-1:0] cnt_q;

   assign tick = !clear && (cnt_q == LAST);

   always_ff @(posedge clk) begin
      if (!reset || clear || tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/seg_display_sched.sv
// Fixed-priority arbiter that scrolls the granted 8-char message through a 4-char window.
module seg_display_sched
   import seg_pkg::*;
#(
   parameter int unsigned STEP_CYCLES = 50_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  req,
   input  logic [63:0] msg0,
   input  logic [63:0] msg1,
   input  logic [63:0] msg2,
   input  logic [2:0]  loop,
   output logic [2:0]  grant,
   output logic        busy,
   output logic        done,
   output logic [31:0] win
);

   localparam logic [3:0] K_LAST = 4'(MSG_CHARS);

   state_e      state_q;
   logic [3:0]  k_q;
   logic [63:0] msg_q;
   logic        loop_q;
   logic        tick;
   logic [2:0]  pick;
   logic [2:0]  src_oh;
   logic [2:0]  above;
   logic        higher;
   logic [63:0] lat_msg;
   logic        lat_loop;

   step_timer #(
      .STEP_CYCLES (STEP_CYCLES)
   ) u_step_timer (
      .clk   (clk),
      .reset (reset),
      .clear (state_q == IDLE),
      .tick  (tick)
   );

   always_comb begin
      pick = 3'b000;
      if (req[SRC_RESULT]) begin
         pick = 3'(1 << SRC_RESULT);
      end else if (req[SRC_LEARN]) begin
         pick = 3'(1 << SRC_LEARN);
      end else if (req[SRC_FREE]) begin
         pick = 3'(1 << SRC_FREE);
      end
   end

   // In IDLE the latch source is the arbiter winner; in SHOW it is the current owner.
   assign src_oh = (state_q == IDLE) ? pick : grant;

   always_comb begin
      lat_msg  = msg0;
      lat_loop = loop[SRC_FREE];
      if (src_oh[SRC_RESULT]) begin
         lat_msg  = msg2;
         lat_loop = loop[SRC_RESULT];
      end else if (src_oh[SRC_LEARN]) begin
         lat_msg  = msg1;
         lat_loop = loop[SRC_LEARN];
      end
   end

   always_comb begin
      case (grant)
         3'b001:  above = 3'b110;
         3'b010:  above = 3'b100;
         default: above = 3'b000;
      endcase
      higher = |(req & above);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         grant   <= 3'b000;
         done    <= 1'b0;
         k_q     <= 4'd0;
         msg_q   <= '0;
         loop_q  <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            IDLE: begin
               k_q <= 4'd0;
               if (|req) begin
                  state_q <= SHOW;
                  grant   <= pick;
                  msg_q   <= lat_msg;
                  loop_q  <= lat_loop;
               end
            end
            SHOW: begin
               if (tick) begin
                  if (k_q == K_LAST) begin
                     done <= 1'b1;
                     k_q  <= 4'd0;
                     if (loop_q && |(req & grant) && !higher) begin
                        msg_q <= lat_msg;
                     end else begin
                        state_q <= IDLE;
                        grant   <= 3'b000;
                     end
                  end else if (higher) begin
                     // Preempted passes end silently.
                     state_q <= IDLE;
                     grant   <= 3'b000;
                     k_q     <= 4'd0;
                  end else begin
                     k_q <= k_q + 4'd1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy = |grant;
   assign win  = window(msg_q, k_q);

endmodule

// File: tb/tb_seg_display_sched.sv
// Directed bench for seg_display_sched with STEP_CYCLES=4; outputs sampled on the falling edge.
module tb_seg_display_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  req;
   logic [63:0] msg0;
   logic [63:0] msg1;
   logic [63:0] msg2;
   logic [2:0]  loop;
   logic [2:0]  grant;
   logic        busy;
   logic        done;
   logic [31:0] win;

   int total = 0;
   int bad   = 0;

   logic [31:0] t1_win [9] = '{32'h00000000, 32'h11000000, 32'h22110000, 32'h33221100,
                               32'h44332211, 32'h55443322, 32'h66554433, 32'h77665544,
                               32'h88776655};

   seg_display_sched #(
      .STEP_CYCLES (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .msg0  (msg0),
      .msg1  (msg1),
      .msg2  (msg2),
      .loop  (loop),
      .grant (grant),
      .busy  (busy),
      .done  (done),
      .win   (win)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Steps falling edges until done or the budget runs out; flags any owner change before done.
   task automatic wait_done(input int max, input logic [2:0] g, output int n, output bit held);
      n    = 0;
      held = 1'b1;
      do begin
         @(negedge clk);
         n++;
         if (done !== 1'b1 && grant !== g) held = 1'b0;
      end while (done !== 1'b1 && n < max);
   endtask

   initial begin
      int n;
      bit held;

      reset = 1'b0;
      req   = 3'b000;
      loop  = 3'b000;
      msg0  = 64'h8877665544332211;
      msg1  = 64'ha8a7a6a5a4a3a2a1;
      msg2  = 64'h0807060504030201;
      repeat (2) @(negedge clk);
      check("rst_grant", grant, 3'b000);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_win", win, 32'h0);

      // Single pass, no loop
      reset = 1'b1;
      req   = 3'b001;
      @(negedge clk);
      check("t1_grant", grant, 3'b001);
      check("t1_busy", busy, 1'b1);
      req = 3'b000;
      for (int i = 0; i < 36; i++) begin
         check($sformatf("t1_win_k%0d_c%0d", i / 4, i % 4), win, t1_win[i / 4]);
         check("t1_no_early_done", done, 1'b0);
         @(negedge clk);
      end
      check("t1_done", done, 1'b1);
      check("t1_done_grant", grant, 3'b000);
      check("t1_done_win", win, 32'h0);
      @(negedge clk);
      check("t1_done_once", done, 1'b0);
      check("t1_idle_busy", busy, 1'b0);

      // Looping owner held for two passes, then dropped at k=2 of the third
      req  = 3'b001;
      loop = 3'b001;
      @(negedge clk);
      check("t2_grant", grant, 3'b001);
      wait_done(40, 3'b001, n, held);
      check("t2_pass1_len", 64'(n), 64'd36);
      check("t2_pass1_held", 64'(held), 64'd1);
      check("t2_pass1_grant", grant, 3'b001);
      check("t2_pass1_win", win, 32'h0);
      wait_done(40, 3'b001, n, held);
      check("t2_pass2_len", 64'(n), 64'd36);
      check("t2_pass2_held", 64'(held), 64'd1);
      check("t2_pass2_grant", grant, 3'b001);
      check("t2_pass2_win", win, 32'h0);
      repeat (8) @(negedge clk);
      check("t5_win_k2", win, 32'h22110000);
      req = 3'b000;
      wait_done(40, 3'b001, n, held);
      check("t5_rest_len", 64'(n), 64'd28);
      check("t5_held", 64'(held), 64'd1);
      check("t5_done_grant", grant, 3'b000);
      check("t5_done_win", win, 32'h0);
      @(negedge clk);
      check("t5_single_done", done, 1'b0);
      check("t5_idle_grant", grant, 3'b000);

      // Preemption of source 0 by source 2 at k=3
      req  = 3'b001;
      loop = 3'b000;
      @(negedge clk);
      check("t3_grant0", grant, 3'b001);
      repeat (12) @(negedge clk);
      check("t3_win_k3", win, 32'h33221100);
      req = 3'b101;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t3_wait_grant", grant, 3'b001);
         check("t3_wait_done", done, 1'b0);
      end
      @(negedge clk);
      check("t3_gap_grant", grant, 3'b000);
      check("t3_gap_busy", busy, 1'b0);
      check("t3_no_done", done, 1'b0);
      @(negedge clk);
      check("t3_grant2", grant, 3'b100);
      check("t3_win_k0", win, 32'h0);
      check("t3_no_done2", done, 1'b0);

      // Reset mid-pass at k=5, then release with req held
      repeat (20) @(negedge clk);
      check("t6_win_k5", win, 32'h05040302);
      reset = 1'b0;
      @(negedge clk);
      check("t6_grant", grant, 3'b000);
      check("t6_busy", busy, 1'b0);
      check("t6_done", done, 1'b0);
      check("t6_win", win, 32'h0);
      @(negedge clk);
      check("t6_done_hold", done, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      check("t6_regrant", grant, 3'b100);
      check("t6_rebusy", busy, 1'b1);

      req   = 3'b000;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Simultaneous requests: source 1 first, then source 0 after a 1-cycle gap
      req = 3'b011;
      @(negedge clk);
      check("t4_grant1", grant, 3'b010);
      req = 3'b001;
      repeat (4) @(negedge clk);
      check("t4_win_k1", win, 32'ha1000000);
      wait_done(40, 3'b010, n, held);
      check("t4_rest_len", 64'(n), 64'd32);
      check("t4_held", 64'(held), 64'd1);
      check("t4_gap_grant", grant, 3'b000);
      check("t4_gap_done", done, 1'b1);
      @(negedge clk);
      check("t4_grant0", grant, 3'b001);
      check("t4_win_k0", win, 32'h0);
      req = 3'b000;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
